// File: rtl/gen_ppbuff_drain_pkg.sv
// Shared types and helpers for the indexed entry buffer drain.
package gen_ppbuff_drain_pkg;

  // Drain sequencer states: waiting for the slot at the read pointer, or
  // holding a captured entry until both the pop and the dequeue complete.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drain_state_e;

  // Index width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned dp);
    return (dp > 1) ? $clog2(dp) : 1;
  endfunction

  localparam int unsigned DEFAULT_DP = 8;
  localparam int unsigned DEFAULT_IW = idx_width(DEFAULT_DP);

  // Read pointer increment with explicit wrap, so the depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned dp);
    return (ptr == dp - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/gen_ppbuff_drain_en_reg.sv
// Enabled register with synchronous active-high reset to zero.
module gen_ppbuff_drain_en_reg #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Load new data only when enabled, otherwise hold.
  always_comb begin
    val_d = en_i ? d_i : val_q;
  end

  // Storage with synchronous reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values; this
  // data register is reset too, so the captured-entry output reads zero after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/gen_ppbuff_drain.sv
// Reader side of the indexed entry buffer: drains slots in strict index order,
// presents each on a valid/ready port and pops it through the shared index mux.
module gen_ppbuff_drain
  import gen_ppbuff_drain_pkg::*;
#(
  parameter  int unsigned DW = 100,
  parameter  int unsigned DP = 8,
  localparam int unsigned IW = idx_width(DP)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic [DW*DP-1:0] buf_info_i,
  input  logic [DP-1:0]    buf_valid_i,
  output logic             buf_pop_o,
  output logic [IW-1:0]    buf_index_o,
  input  logic             pop_gnt_i,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [DW-1:0]    deq_data_o,
  output logic [IW-1:0]    deq_index_o,
  output logic             idle_o
);

  drain_state_e  state_q, state_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pop_pend_q, pop_pend_d;
  logic          out_pend_q, out_pend_d;
  logic          capture;
  logic [DW-1:0] slot_data;
  logic [DW-1:0] data_q;
  logic [IW-1:0] idx_q;

  // Select the entry at the read pointer; other slots are never looked at.
  always_comb begin
    slot_data = buf_info_i[DW*32'(rd_ptr_q) +: DW];
  end

  // Next-state logic: flush wins, then capture in IDLE or handshake tracking in HOLD.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    pop_pend_d = pop_pend_q;
    out_pend_d = out_pend_q;
    capture    = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      rd_ptr_d   = '0;
      pop_pend_d = 1'b0;
      out_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (buf_valid_i[rd_ptr_q]) begin
            capture    = 1'b1;
            pop_pend_d = 1'b1;
            out_pend_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          // Pop and dequeue complete independently; a grant with nothing pending is ignored.
          pop_pend_d = pop_pend_q & ~pop_gnt_i;
          out_pend_d = out_pend_q & ~deq_ready_i;
          if (!pop_pend_d && !out_pend_d) begin
            rd_ptr_d = IW'(ptr_inc(32'(rd_ptr_q), DP));
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      pop_pend_q <= 1'b0;
      out_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      pop_pend_q <= pop_pend_d;
      out_pend_q <= out_pend_d;
    end
  end

  // Captured entry and its slot number, loaded once per drained slot and held through HOLD.
  gen_ppbuff_drain_en_reg #(.W(DW)) u_data_reg (
    .CLK  (CLK),
    .RST  (RST),
    .en_i (capture),
    .d_i  (slot_data),
    .q_o  (data_q)
  );

  gen_ppbuff_drain_en_reg #(.W(IW)) u_idx_reg (
    .CLK  (CLK),
    .RST  (RST),
    .en_i (capture),
    .d_i  (rd_ptr_q),
    .q_o  (idx_q)
  );

  // The pop is masked during flush because the buffer clears itself on the same edge.
  assign buf_pop_o   = pop_pend_q & ~flush;
  assign buf_index_o = rd_ptr_q;
  assign deq_valid_o = out_pend_q;
  assign deq_data_o  = data_q;
  assign deq_index_o = idx_q;
  assign idle_o      = (state_q == IDLE);

endmodule

// File: tb/tb_gen_ppbuff_drain.sv
// Scoreboard bench for gen_ppbuff_drain with DW=8, DP=4.
module tb_gen_ppbuff_drain;

  localparam int DW = 8;
  localparam int DP = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             flush;
  logic [DW*DP-1:0] buf_info_i;
  logic [DP-1:0]    buf_valid_i;
  logic             buf_pop_o;
  logic [1:0]       buf_index_o;
  logic             pop_gnt_i;
  logic             deq_valid_o;
  logic             deq_ready_i;
  logic [DW-1:0]    deq_data_o;
  logic [1:0]       deq_index_o;
  logic             idle_o;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
  } deq_t;

  deq_t       exp_deq[$];
  logic [1:0] exp_pop[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 CLK = ~CLK;

  gen_ppbuff_drain #(.DW(DW), .DP(DP)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .buf_info_i  (buf_info_i),
    .buf_valid_i (buf_valid_i),
    .buf_pop_o   (buf_pop_o),
    .buf_index_o (buf_index_o),
    .pop_gnt_i   (pop_gnt_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_data_o  (deq_data_o),
    .deq_index_o (deq_index_o),
    .idle_o      (idle_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change only here.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_slot(input logic [1:0] ix, input logic [7:0] d);
    buf_info_i[DW*ix +: DW] = d;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] ix);
    deq_t e;
    e.data = d;
    e.idx  = ix;
    exp_deq.push_back(e);
    exp_pop.push_back(ix);
  endtask

  // Drain one slot with grant and ready held high; rd_ptr must equal ix on entry.
  task automatic drain_one(input logic [7:0] d, input logic [1:0] ix, input logic [1:0] nx,
                           input string tag);
    set_slot(ix, d);
    buf_valid_i[ix] = 1'b1;
    push_exp(d, ix);
    @(negedge CLK);
    check({tag, "_idle_capture"}, idle_o, 1);
    check({tag, "_no_pop_capture"}, buf_pop_o, 0);
    cyc();
    @(negedge CLK);
    check({tag, "_deq_valid"}, deq_valid_o, 1);
    check({tag, "_pop"}, buf_pop_o, 1);
    check({tag, "_buf_index"}, buf_index_o, ix);
    check({tag, "_deq_data"}, deq_data_o, d);
    cyc();
    buf_valid_i[ix] = 1'b0;
    @(negedge CLK);
    check({tag, "_idle_after"}, idle_o, 1);
    check({tag, "_rd_ptr_next"}, buf_index_o, nx);
    cyc();
  endtask

  // Monitor: compare every completed dequeue and every granted pop against the scoreboard.
  always @(negedge CLK) begin
    deq_t       e;
    logic [1:0] p;
    if (!RST && deq_valid_o && deq_ready_i) begin
      if (exp_deq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_deq_unexpected: got data 0x%0h idx %0d, expected no dequeue",
                 deq_data_o, deq_index_o);
      end else begin
        e = exp_deq.pop_front();
        check("sb_deq_data", deq_data_o, e.data);
        check("sb_deq_index", deq_index_o, e.idx);
      end
    end
    if (!RST && buf_pop_o && pop_gnt_i) begin
      if (exp_pop.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_pop_unexpected: got pop of slot %0d, expected no pop", buf_index_o);
      end else begin
        p = exp_pop.pop_front();
        check("sb_pop_index", buf_index_o, p);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops;
    RST         = 1'b1;
    flush       = 1'b0;
    pop_gnt_i   = 1'b0;
    deq_ready_i = 1'b0;
    buf_valid_i = 4'b1111;
    buf_info_i  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

    // Reset held for two edges with every slot valid.
    cyc();
    cyc();
    @(negedge CLK);
    check("rst_deq_valid", deq_valid_o, 0);
    check("rst_pop", buf_pop_o, 0);
    check("rst_buf_index", buf_index_o, 0);
    check("rst_deq_data", deq_data_o, 8'h00);
    check("rst_deq_index", deq_index_o, 0);
    check("rst_idle", idle_o, 1);
    cyc();
    RST         = 1'b0;
    buf_valid_i = 4'b0000;
    buf_info_i  = '0;

    // Out-of-order slot is never drained while rd_ptr points elsewhere.
    buf_valid_i = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("ooo_no_pop", buf_pop_o, 0);
      check("ooo_no_deq", deq_valid_o, 0);
      cyc();
    end
    buf_valid_i = 4'b0000;
    @(negedge CLK);
    check("ooo_rd_ptr_held", buf_index_o, 0);
    cyc();

    // Single entry with grant and ready.
    pop_gnt_i   = 1'b1;
    deq_ready_i = 1'b1;
    drain_one(8'hA5, 2'd0, 2'd1, "single");

    // Flush while idle returns rd_ptr to 0.
    flush = 1'b1;
    @(negedge CLK);
    check("idle_flush_no_pop", buf_pop_o, 0);
    cyc();
    flush = 1'b0;
    @(negedge CLK);
    check("idle_flush_rd_ptr", buf_index_o, 0);
    check("idle_flush_idle", idle_o, 1);
    cyc();

    // Backpressure: ready low for three HOLD cycles, grant always high.
    pop_gnt_i   = 1'b1;
    deq_ready_i = 1'b0;
    set_slot(2'd0, 8'h11);
    buf_valid_i[0] = 1'b1;
    push_exp(8'h11, 2'd0);
    @(negedge CLK);
    check("bp_idle_capture", idle_o, 1);
    cyc();
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) buf_valid_i[0] = 1'b0;
      if (i == 3) deq_ready_i = 1'b1;
      @(negedge CLK);
      check("bp_deq_valid", deq_valid_o, 1);
      check("bp_deq_data", deq_data_o, 8'h11);
      check("bp_deq_index", deq_index_o, 0);
      check("bp_rd_ptr_held", buf_index_o, 0);
      pops += int'(buf_pop_o);
      cyc();
    end
    check("bp_pop_count", pops, 1);
    @(negedge CLK);
    check("bp_idle_after", idle_o, 1);
    check("bp_rd_ptr_next", buf_index_o, 1);
    check("bp_deq_dropped", deq_valid_o, 0);
    cyc();

    // Grant denial: dequeue completes first, pop stays up until granted.
    pop_gnt_i   = 1'b0;
    deq_ready_i = 1'b1;
    set_slot(2'd1, 8'h5A);
    buf_valid_i[1] = 1'b1;
    push_exp(8'h5A, 2'd1);
    @(negedge CLK);
    check("gd_idle_capture", idle_o, 1);
    cyc();
    @(negedge CLK);
    check("gd_pop_1", buf_pop_o, 1);
    check("gd_index_1", buf_index_o, 1);
    check("gd_deq_valid_1", deq_valid_o, 1);
    check("gd_deq_data_1", deq_data_o, 8'h5A);
    cyc();
    @(negedge CLK);
    check("gd_pop_2", buf_pop_o, 1);
    check("gd_index_2", buf_index_o, 1);
    check("gd_deq_done", deq_valid_o, 0);
    check("gd_still_hold_2", idle_o, 0);
    cyc();
    pop_gnt_i = 1'b1;
    @(negedge CLK);
    check("gd_pop_3", buf_pop_o, 1);
    check("gd_index_3", buf_index_o, 1);
    check("gd_still_hold_3", idle_o, 0);
    cyc();
    buf_valid_i[1] = 1'b0;
    @(negedge CLK);
    check("gd_idle_after", idle_o, 1);
    check("gd_rd_ptr_next", buf_index_o, 2);
    check("gd_pop_after", buf_pop_o, 0);
    cyc();

    // Wrap: slots 2 and 3, then back to slot 0.
    pop_gnt_i   = 1'b1;
    deq_ready_i = 1'b1;
    drain_one(8'h22, 2'd2, 2'd3, "wrap2");
    drain_one(8'h33, 2'd3, 2'd0, "wrap3");
    drain_one(8'h3C, 2'd0, 2'd1, "wrap0");

    // Flush during HOLD discards the held entry.
    pop_gnt_i   = 1'b0;
    deq_ready_i = 1'b0;
    set_slot(2'd1, 8'h77);
    buf_valid_i[1] = 1'b1;
    @(negedge CLK);
    check("fl_idle_capture", idle_o, 1);
    cyc();
    @(negedge CLK);
    check("fl_hold_pop", buf_pop_o, 1);
    check("fl_hold_deq_valid", deq_valid_o, 1);
    check("fl_hold_data", deq_data_o, 8'h77);
    cyc();
    flush = 1'b1;
    @(negedge CLK);
    check("fl_pop_masked", buf_pop_o, 0);
    cyc();
    flush       = 1'b0;
    buf_valid_i = 4'b0000;
    @(negedge CLK);
    check("fl_deq_valid", deq_valid_o, 0);
    check("fl_rd_ptr", buf_index_o, 0);
    check("fl_idle", idle_o, 1);
    check("fl_no_pop", buf_pop_o, 0);
    cyc();
    cyc();

    check("sb_deq_drained", exp_deq.size(), 0);
    check("sb_pop_drained", exp_pop.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_ppbuff_drain.md
Name: gen_ppbuff_drain

Overview:
- Reader side of the indexed entry buffer. It drains valid entries in strict index order (0,1,…,DP-1, wrap) and presents each one on a valid/ready dequeue port.
- It drives the buffer's pop and index lines to release each drained slot.
- The buffer's index port is shared with the writer, so every pop goes through a request/grant handshake with the external index mux. The writer has priority.

Parameters:
- DW, 100, entry width in bits.
- DP, 8, buffer depth. Need not be a power of two; wrap is explicit.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush, same net as the buffer's flush.
- buf_info_i  input  DW*DP  buffer contents; slot k is at [DW*k +: DW].
- buf_valid_i  input  DP  per-slot valid from the buffer.
- buf_pop_o  output  1  pop request for slot buf_index_o.
- buf_index_o  output  $clog2(DP)  slot being popped; equals the read pointer.
- pop_gnt_i  input  1  index mux grants the pop this cycle; the slot clears at the next edge.
- deq_valid_o  output  1  dequeue data valid.
- deq_ready_i  input  1  consumer accepts.
- deq_data_o  output  DW  captured entry.
- deq_index_o  output  $clog2(DP)  slot the captured entry came from.
- idle_o  output  1  drain is in IDLE.

Behaviour:
Registers:
- rd_ptr (0..DP-1)
- state (IDLE, HOLD)
- pop_pend, out_pend
- data_q (DW), idx_q
- All registers reset to 0 / IDLE on RST.

Outputs:
- After reset: deq_valid_o=0, buf_pop_o=0, buf_index_o=0, deq_data_o=0, deq_index_o=0, idle_o=1.

IDLE:
- If buf_valid_i[rd_ptr] & ~flush: capture data_q ← slot rd_ptr and idx_q ← rd_ptr, set pop_pend=1 and out_pend=1, go to HOLD.
- Valid slots other than rd_ptr are ignored. There is no skipping and no search.

HOLD:
- buf_pop_o = pop_pend & ~flush. buf_index_o = rd_ptr.
- deq_valid_o = out_pend. deq_data_o = data_q.
- pop_gnt_i while pop_pend clears pop_pend.
- deq_valid_o & deq_ready_i clears out_pend.
- The two handshakes are independent; either may complete first, or both in the same cycle.
- When both are clear (counting clears in the current cycle): rd_ptr ← (rd_ptr==DP-1) ? 0 : rd_ptr+1, go to IDLE.
- No back-to-back overlap: the next capture is earliest one cycle after returning to IDLE.

Timing and latency:
- Slot valid seen in cycle N → deq_valid_o and buf_pop_o in cycle N+1.
- With grant and ready both present, throughput is one entry per 2 cycles.

Stability rules:
- deq_data_o and deq_index_o stay stable while deq_valid_o=1.
- deq_valid_o never drops without a handshake, except on flush or RST.
- buf_index_o is stable while buf_pop_o=1.

Flush:
- Flush has priority over all other transitions.
- At the next edge: state=IDLE, rd_ptr=0, pop_pend=out_pend=0. A held entry is discarded.
- buf_pop_o is masked in the flush cycle; the buffer clears itself.

RST mid-HOLD:
- Same effect as flush; data_q is also zeroed.

pop_gnt_i:
- Ignored when pop_pend=0.

Decomposition:
- Shared package:
  - drain state enum {IDLE, HOLD}.
  - Index width localparam derived from DP.
  - Function ptr_inc(ptr, DP) implementing the wrap.
- No sub-module needed. data_q and idx_q use the team's existing enabled-register primitive, adapted to synchronous active-high reset.

Test Plan:
Bench uses DW=8, DP=4.
1. Reset: hold RST=1 for 2 cycles with buf_valid_i=4'b1111 → deq_valid_o=0, buf_pop_o=0, buf_index_o=0, deq_data_o=8'h00, idle_o=1.
2. Single entry: valid=4'b0001, slot0=8'hA5, gnt=1, ready=1 → next cycle buf_pop_o=1, idx=0, deq_valid_o=1, data=8'hA5; the cycle after, idle_o=1 and rd_ptr=1.
3. Out-of-order hold-off: valid=4'b0100 with rd_ptr=0, for 10 cycles → buf_pop_o=0 and deq_valid_o=0 throughout.
4. Backpressure: slot0=8'h11, gnt=1, ready=0 for 3 cycles, then 1 → exactly one pop cycle; deq_data_o=8'h11 stable for 4 cycles; rd_ptr advances only after ready.
5. Grant denial: gnt=0 for 2 cycles, ready=1 → dequeue completes first; buf_pop_o stays 1 with buf_index_o stable until gnt; advance occurs in the grant cycle.
6. Wrap and flush: drain slots 0..3, then slot0=8'h3C → deq_data_o=8'h3C. Re-fill slot1 and assert flush while in HOLD → deq_valid_o=0 next cycle, rd_ptr=0, no pop in the flush cycle.
